// File: rtl/obi_tcdm_arbiter_pkg.sv
// obi_tcdm_arbiter_pkg
//   Shared helpers for the OBI -> TCDM arbiter slice.
//   idx_width(n): bit width needed to hold an index in [0, n-1]. It never
//   returns less than 1, so a degenerate n=1 still yields a legal vector.
package obi_tcdm_arbiter_pkg;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_fifo_idx.sv
// rr_fifo_idx
//   Small synchronous FIFO holding requester indices for in-order response
//   routing. Depth need not be a power of two; the pointers wrap explicitly.
//   A push while full or a pop while empty is ignored, so the FIFO state
//   stays consistent even if the caller misbehaves.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_push/i_data write one entry
//   i_pop         drop the head entry
//   o_data        head entry (valid when !o_empty)
//   o_full        count == Depth
//   o_empty       count == 0
//   o_count       current occupancy
module rr_fifo_idx
  import obi_tcdm_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  localparam int unsigned PtrW = idx_width(Depth);

  logic [Depth-1:0][Width-1:0] r_mem;
  logic [PtrW-1:0]             r_wr;
  logic [PtrW-1:0]             r_rd;
  logic [CntW-1:0]             r_cnt;
  logic                        w_push;
  logic                        w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage needs no reset: nothing reads an entry before it is written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/obi_tcdm_arbiter.sv
// obi_tcdm_arbiter
//   Shares one TCDM port between NumReq OBI requesters. Arbitration is
//   combinational round-robin starting at r_ptr; each accepted TCDM request
//   pushes the winner index into a routing FIFO, and each in-order TCDM
//   response pops it to steer rvalid back to the originating requester.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   obi_req_i/we/addr/wdata/be  per-requester OBI request (flat, index-major)
//   obi_gnt_o               grant, one-hot or zero
//   obi_rvalid_o            response valid, one-hot or zero
//   obi_rdata_o             response data broadcast to all requesters
//   tcdm_q_*                TCDM request channel (fields zero when !valid)
//   tcdm_p_valid_i/data_i   TCDM response channel
//   outstanding_o           routing FIFO occupancy
//   err_o                   sticky: response arrived with nothing outstanding
module obi_tcdm_arbiter
  import obi_tcdm_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReq-1:0]                  obi_req_i,
  input  logic [NumReq-1:0]                  obi_we_i,
  input  logic [NumReq*AddrWidth-1:0]        obi_addr_i,
  input  logic [NumReq*DataWidth-1:0]        obi_wdata_i,
  input  logic [NumReq*(DataWidth/8)-1:0]    obi_be_i,
  output logic [NumReq-1:0]                  obi_gnt_o,
  output logic [NumReq-1:0]                  obi_rvalid_o,
  output logic [DataWidth-1:0]               obi_rdata_o,
  output logic                               tcdm_q_valid_o,
  output logic                               tcdm_q_write_o,
  output logic [AddrWidth-1:0]               tcdm_q_addr_o,
  output logic [DataWidth-1:0]               tcdm_q_data_o,
  output logic [DataWidth/8-1:0]             tcdm_q_strb_o,
  input  logic                               tcdm_q_ready_i,
  input  logic                               tcdm_p_valid_i,
  input  logic [DataWidth-1:0]               tcdm_p_data_i,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                               err_o
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned IdxW  = idx_width(NumReq);

  // Per-requester views of the flat request buses.
  logic [NumReq-1:0][AddrWidth-1:0] w_addr_arr;
  logic [NumReq-1:0][DataWidth-1:0] w_wdata_arr;
  logic [NumReq-1:0][StrbW-1:0]     w_be_arr;

  logic [IdxW-1:0]     r_ptr;
  logic                r_err;
  logic [2*NumReq-1:0] w_dbl;
  logic [NumReq-1:0]   w_rot;
  logic [IdxW-1:0]     w_off;
  logic [IdxW:0]       w_sum;
  logic [IdxW-1:0]     w_winner;
  logic [IdxW-1:0]     w_ptr_nxt;
  logic [IdxW-1:0]     w_head;
  logic                w_found;
  logic                w_full;
  logic                w_empty;
  logic                w_qv;
  logic                w_hs;
  logic                w_pop;

  assign w_addr_arr  = obi_addr_i;
  assign w_wdata_arr = obi_wdata_i;
  assign w_be_arr    = obi_be_i;

  // Rotate the request vector so bit 0 is the requester at r_ptr; the first
  // set bit is then the offset of the round-robin winner from r_ptr.
  assign w_dbl = {obi_req_i, obi_req_i};
  assign w_rot = NumReq'(w_dbl >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IdxW'(k);
      end
    end
  end

  // Winner = (r_ptr + offset) mod NumReq, without a divider.
  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_winner = (w_sum >= (IdxW+1)'(NumReq)) ? IdxW'(w_sum - (IdxW+1)'(NumReq))
                                                 : IdxW'(w_sum);
  assign w_ptr_nxt = (w_winner == IdxW'(NumReq - 1)) ? '0 : w_winner + 1'b1;

  // Eligibility looks only at the registered full flag, so a same-cycle pop
  // never opens a combinational path from p_valid to q_valid/gnt.
  assign w_qv  = ~rst_i & w_found & ~w_full;
  assign w_hs  = w_qv & tcdm_q_ready_i;
  assign w_pop = ~rst_i & tcdm_p_valid_i & ~w_empty;

  assign tcdm_q_valid_o = w_qv;
  assign tcdm_q_write_o = w_qv & obi_we_i[w_winner];
  assign tcdm_q_addr_o  = w_qv ? w_addr_arr[w_winner]  : '0;
  assign tcdm_q_data_o  = w_qv ? w_wdata_arr[w_winner] : '0;
  assign tcdm_q_strb_o  = w_qv ? w_be_arr[w_winner]    : '0;

  assign obi_gnt_o    = w_hs  ? (NumReq'(1) << w_winner) : '0;
  assign obi_rvalid_o = w_pop ? (NumReq'(1) << w_head)   : '0;
  assign obi_rdata_o  = rst_i ? '0 : tcdm_p_data_i;
  assign err_o        = r_err;

  // r_ptr only advances on a handshake, so a stalled winner stays selected
  // while its OBI request is held stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) r_ptr <= w_ptr_nxt;
      if (tcdm_p_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  rr_fifo_idx #(
    .Depth (MaxOutstanding),
    .Width (IdxW),
    .CntW  ($clog2(MaxOutstanding + 1))
  ) u_route_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_hs),
    .i_data  (w_winner),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

endmodule

// File: tb/tb_obi_tcdm_arbiter.sv
module tb_obi_tcdm_arbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, we;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][DW-1:0] wdata;
  logic [N-1:0][SW-1:0] be;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata;
  logic qv, qw;
  logic [AW-1:0] qa;
  logic [DW-1:0] qd;
  logic [SW-1:0] qs;
  logic q_ready, p_valid;
  logic [DW-1:0] p_data;
  logic [CW-1:0] outst;
  logic err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: round-robin pointer, queue of in-flight requester
  // indices (oldest first), sticky orphan flag.
  int m_ptr = 0;
  int m_q[$];
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  obi_tcdm_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .obi_req_i      (req),
    .obi_we_i       (we),
    .obi_addr_i     (addr),
    .obi_wdata_i    (wdata),
    .obi_be_i       (be),
    .obi_gnt_o      (gnt),
    .obi_rvalid_o   (rvalid),
    .obi_rdata_o    (rdata),
    .tcdm_q_valid_o (qv),
    .tcdm_q_write_o (qw),
    .tcdm_q_addr_o  (qa),
    .tcdm_q_data_o  (qd),
    .tcdm_q_strb_o  (qs),
    .tcdm_q_ready_i (q_ready),
    .tcdm_p_valid_i (p_valid),
    .tcdm_p_data_i  (p_data),
    .outstanding_o  (outst),
    .err_o          (err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare on the falling edge (inputs stable), then advance the model as
  // the following rising edge will.
  always @(negedge clk) begin : cmp
    int w;
    bit found, full, eqv, ehs, epop;
    logic [N-1:0] eg, erv;
    if (rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_q_valid", qv, 0);
      chk("rst_q_addr", qa, 0);
      chk("rst_outstanding", outst, 0);
      chk("rst_err", err, 0);
      m_ptr = 0;
      m_q.delete();
      m_err = 1'b0;
    end else begin
      full  = (m_q.size() == MAXO);
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!found && req[i]) begin
          found = 1'b1;
          w     = i;
        end
      end
      eqv  = found && !full;
      ehs  = eqv && q_ready;
      epop = p_valid && (m_q.size() > 0);
      eg   = '0;
      erv  = '0;
      if (ehs)  eg[w] = 1'b1;
      if (epop) erv[m_q[0]] = 1'b1;
      chk("q_valid", qv, eqv);
      chk("gnt", gnt, eg);
      chk("q_write", qw, eqv ? we[w] : 1'b0);
      chk("q_addr", qa, eqv ? addr[w] : 32'h0);
      chk("q_data", qd, eqv ? wdata[w] : 32'h0);
      chk("q_strb", qs, eqv ? be[w] : 4'h0);
      chk("rvalid", rvalid, erv);
      chk("rdata", rdata, p_data);
      chk("outstanding", outst, m_q.size());
      chk("err", err, m_err);
      if (p_valid && m_q.size() == 0) m_err = 1'b1;
      if (epop) void'(m_q.pop_front());
      if (ehs) begin
        m_q.push_back(w);
        m_ptr = (w + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [N-1:0] e;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    q_ready = 1'b0; p_valid = 1'b0; p_data = '0;
    tick();
    tick();
    #2;
    chk("lit_reset_outstanding", outst, 0);
    chk("lit_reset_gnt", gnt, 0);
    chk("lit_reset_err", err, 0);
    tick();
    rst = 1'b0;

    // Single requester read, response two cycles after the handshake.
    tick();
    req = 4'b0100; we = '0; addr[2] = 32'h100; q_ready = 1'b1;
    #2;
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_q_addr", qa, 32'h100);
    tick();
    req = '0;
    #2 chk("t1_outstanding_1", outst, 1);
    tick();
    p_valid = 1'b1; p_data = 32'hCAFE;
    #2;
    chk("t1_rvalid", rvalid, 4'b0100);
    chk("t1_rdata", rdata, 32'hCAFE);
    tick();
    p_valid = 1'b0;
    #2 chk("t1_outstanding_0", outst, 0);

    // All requesters, ptr at 0, responses one cycle later.
    do_reset();
    req = 4'b1111; q_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      p_valid = (c >= 1);
      p_data  = $urandom;
      if (c == 5) req = '0;
      #2;
      if (c < 5) begin
        e = 4'b0001 << (c % 4);
        chk("t2_gnt_order", gnt, e);
      end
      if (c >= 1) begin
        e = 4'b0001 << ((c - 1) % 4);
        chk("t2_rvalid_route", rvalid, e);
      end
      tick();
    end
    p_valid = 1'b0;

    // Fill the routing FIFO with responses withheld (ptr now 1).
    req = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #2;
      e = 4'b0001 << ((1 + c) % 4);
      chk("t3_fill_gnt", gnt, e);
      tick();
    end
    #2;
    chk("t3_full_q_valid", qv, 0);
    chk("t3_full_gnt", gnt, 0);
    chk("t3_full_outstanding", outst, 4);
    tick();
    p_valid = 1'b1;
    #2;
    chk("t3_pop_no_gnt", gnt, 0);
    chk("t3_pop_rvalid", rvalid, 4'b0010);
    tick();
    p_valid = 1'b0;
    #2;
    chk("t3_fifth_gnt", gnt, 4'b0010);
    chk("t3_outstanding_3", outst, 3);
    tick();
    req = '0; p_valid = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    p_valid = 1'b0;

    // Stall: q_ready low keeps the same winner and address.
    do_reset();
    req = 4'b1010; addr[1] = 32'h111; addr[3] = 32'h333; q_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("t4_stall_q_valid", qv, 1);
      chk("t4_stall_addr", qa, 32'h111);
      chk("t4_stall_gnt", gnt, 0);
      tick();
    end
    q_ready = 1'b1;
    #2 chk("t4_gnt1", gnt, 4'b0010);
    tick();
    #2 chk("t4_gnt3", gnt, 4'b1000);
    tick();
    req = '0; p_valid = 1'b1;
    tick();
    tick();
    p_valid = 1'b0;

    // Orphan response.
    p_valid = 1'b1;
    #2 chk("t5_orphan_rvalid", rvalid, 0);
    tick();
    p_valid = 1'b0;
    #2 chk("t5_err_set", err, 1);
    tick();
    tick();
    #2 chk("t5_err_sticky", err, 1);
    do_reset();
    #2;
    chk("t5_err_cleared", err, 0);
    chk("t5_outstanding_cleared", outst, 0);

    // Asynchronous reset with two requests outstanding.
    tick();
    req = 4'b0011; q_ready = 1'b1;
    tick();
    tick();
    q_ready = 1'b0;
    #2 chk("t6_outstanding_2", outst, 2);
    rst = 1'b1; q_ready = 1'b1;
    #1;
    chk("t6_async_q_valid", qv, 0);
    chk("t6_async_gnt", gnt, 0);
    chk("t6_async_outstanding", outst, 0);
    tick();
    tick();
    rst = 1'b0;
    req = 4'b0100;
    #2 chk("t6_post_gnt", gnt, 4'b0100);
    tick();
    req = '0;
    tick();
    p_valid = 1'b1; p_data = 32'h1234;
    #2;
    chk("t6_post_rvalid", rvalid, 4'b0100);
    chk("t6_post_err", err, 0);
    tick();
    p_valid = 1'b0;

    // Randomised traffic; the TCDM side only responds for accepted requests.
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      req     = N'($urandom);
      we      = N'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[i]  = $urandom;
        wdata[i] = $urandom;
        be[i]    = SW'($urandom);
      end
      q_ready = ($urandom_range(0, 3) != 0);
      p_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      p_data  = $urandom;
      tick();
    end
    rst = 1'b0; req = '0; p_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/obi_tcdm_arbiter.md
Name: obi_tcdm_arbiter

Overview:
- Shares one TCDM port between NumReq OBI requesters. Uses round-robin arbitration with in-order response routing.
- Sits between core/accelerator OBI masters and a single TCDM bank port, upstream of the OBI-to-TCDM conversion.
- A FIFO of requester indices records each accepted TCDM request, so the in-order TCDM responses can be steered back to the correct requester.

Parameters:
- NumReq, 4, number of OBI requesters (>=2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- MaxOutstanding, 4, depth of the routing FIFO (>=1). It bounds the number of in-flight TCDM transactions.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- obi_req_i  in  NumReq  per-requester request.
- obi_we_i  in  NumReq  write enable.
- obi_addr_i  in  NumReq*AddrWidth  address.
- obi_wdata_i  in  NumReq*DataWidth  write data.
- obi_be_i  in  NumReq*DataWidth/8  byte enables.
- obi_gnt_o  out  NumReq  grant; one-hot or zero.
- obi_rvalid_o  out  NumReq  response valid; one-hot or zero.
- obi_rdata_o  out  DataWidth  response data, broadcast to all requesters.
- tcdm_q_valid_o  out  1  TCDM request valid.
- tcdm_q_write_o  out  1  TCDM write.
- tcdm_q_addr_o  out  AddrWidth  TCDM address.
- tcdm_q_data_o  out  DataWidth  TCDM write data.
- tcdm_q_strb_o  out  DataWidth/8  TCDM strobe.
- tcdm_q_ready_i  in  1  TCDM request ready.
- tcdm_p_valid_i  in  1  TCDM response valid.
- tcdm_p_data_i  in  DataWidth  TCDM response data.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO occupancy.
- err_o  out  1  sticky: a response arrived while the FIFO was empty.

Behaviour:
- Reset (async, rst_i=1):
  - FIFO empty, RR pointer=0, err_o=0, outstanding_o=0.
  - All outputs 0: gnt, rvalid, q_valid, q_* fields.
  - Reset mid-transaction drops all in-flight routing state. Any TCDM responses arriving after reset release count as orphans and set err_o.
- Arbitration:
  - Combinational, round-robin starting at the RR pointer.
  - The winner is the first index i >= ptr (wrapping modulo NumReq) with obi_req_i[i]=1.
  - Eligible only when the FIFO is not full. A full FIFO forces tcdm_q_valid_o=0 and gnt=0, even if a pop occurs in the same cycle. There is no combinational path from p_valid to q_valid/gnt.
- TCDM request:
  - tcdm_q_valid_o=1 when any req is eligible.
  - q_write/q_addr/q_data/q_strb are muxed from the winner. They are 0 when q_valid=0.
- Grant:
  - obi_gnt_o[winner] = tcdm_q_valid_o & tcdm_q_ready_i (combinational).
  - On handshake: push the winner index into the FIFO, and ptr <= (winner+1) mod NumReq.
  - Without a handshake, ptr holds. This preserves the winner while OBI req/addr are held stable.
- Response:
  - TCDM returns exactly one p_valid per accepted request, for reads and writes, in order, at least 1 cycle after the q handshake.
  - On tcdm_p_valid_i with the FIFO non-empty: obi_rvalid_o[head]=1 and obi_rdata_o=tcdm_p_data_i (combinational), then pop.
  - obi_rdata_o is passed through from tcdm_p_data_i in every cycle.
- Simultaneous push and pop (FIFO not full): both occur and occupancy is unchanged. With the FIFO at MaxOutstanding-1, push+pop leaves it at MaxOutstanding-1.
- FIFO full: no grant. The pop completes; arbitration resumes the next cycle.
- FIFO empty with p_valid: no rvalid, no pop, err_o<=1 (sticky until reset).
- Occupancy and pointers:
  - outstanding_o is updated registered: +1 on push only, -1 on pop only.
  - FIFO pointers wrap modulo MaxOutstanding; non-power-of-2 depths are supported.
- Latency:
  - Grant is zero-cycle relative to req when eligible and TCDM is ready.
  - Response routing adds no latency.
  - Throughput is one request per cycle while not full.

Decomposition:
- Package obi_tcdm_arbiter_pkg: idx_t = logic [$clog2(NumReq)-1:0] helper width function; no other constants.
- Sub-module rr_fifo_idx: a small synchronous FIFO (push/pop/full/empty/count) storing idx_t, parameterised by depth.
- Arbitration stays inline.

Test Plan:
- Single requester read: req[2]=1, addr=0x100, q_ready=1; p_valid 2 cycles later with data 0xCAFE -> gnt[2] in cycle 0, rvalid[2]=1, rdata=0xCAFE, outstanding 1->0.
- All 4 requesters assert req continuously with q_ready=1, ptr=0, responses 1 cycle later -> grants in order 0,1,2,3,0; each rvalid routed to the matching index.
- MaxOutstanding=4 with responses withheld -> 4 grants, then q_valid=0 and gnt=0. Release one p_valid -> one cycle later a 5th grant is issued.
- q_ready=0 for 3 cycles while req[1] and req[3] are asserted -> winner stays 1 with stable addr; ptr does not move; gnt[1] issued when q_ready rises.
- p_valid with the FIFO empty -> no rvalid, err_o=1 and stays 1. After rst_i pulse: err_o=0, outstanding_o=0.
- Assert rst_i asynchronously with 2 requests outstanding -> outputs go to 0 immediately; after release, the next request routes correctly.
